dmem_mmio_responder: RTL and testbench
======================================

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, data RAM depth in 32-bit words, indexed by addr[9:2].
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, console TX FIFO depth in bytes (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port write  input  1  bus write strobe from the CPU, one transfer per cycle.
REQ-006 SHALL have port read  input  1  bus read strobe from the CPU.
REQ-007 SHALL have port addr  input  32  byte address; addr[1:0] ignored.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  registered read data.
REQ-010 SHALL have port tx_data  output  8  console byte at FIFO head.
REQ-011 SHALL have port tx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-013 SHALL have port timer_irq  output  1  sticky timer-match flag.
REQ-014 SHALL have port err_unmapped  output  1  sticky flag: an access hit an unmapped region.

Function
REQ-015 SHALL decode addr[31:12]: 0x00000 RAM; 0x00001 timer page; 0x00002 console page; all other values are unmapped.
REQ-016 SHALL return read data on rdata at the posedge after the cycle in which read is high (1-cycle latency), with no wait states.
REQ-017 SHALL hold rdata unchanged in cycles that follow a cycle with read low.
REQ-018 SHALL, when read and write are high together, perform the write and return the pre-write value on rdata.
REQ-019 SHALL write RAM[addr[9:2]] = wdata on write to the RAM region; RAM contents are not reset.
REQ-020 SHALL keep a 32-bit counter TIME that increments by 1 every cycle, wrapping from 0xFFFFFFFF to 0.
REQ-021 SHALL map timer registers: 0x1000 TIME (R/W; a write loads wdata, and the increment resumes the next cycle); 0x1004 CMP (R/W); 0x1008 STAT (bit0 = timer_irq; writing 1 to bit0 clears it).
REQ-022 SHALL set timer_irq in the cycle after TIME == CMP; set takes priority over a same-cycle clear.
REQ-023 SHALL map console registers: 0x2000 TXDATA (write pushes wdata[7:0]; reads return 0); 0x2004 TXSTAT (bit0 full, bit1 empty, bit2 overflow, bits[7:4] count; writing 1 to bit2 clears overflow).
REQ-024 SHALL pop the FIFO head when tx_valid && tx_ready; tx_data SHALL equal the head entry whenever tx_valid is high.
REQ-025 SHALL drop a push to a full FIFO and set overflow, except when a pop occurs in the same cycle, in which case the push is accepted and count is unchanged.
REQ-026 SHALL accept a push to an empty FIFO with no pop; tx_valid rises the next cycle.
REQ-027 SHALL keep count in the range 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL return 0 for unmapped reads and for undefined offsets in mapped pages, and SHALL ignore the matching writes.
REQ-029 SHALL set err_unmapped on any read or write to an unmapped region; the flag stays set until reset.

Reset
REQ-030 SHALL, while reset is high, force rdata=0, TIME=0, CMP=0xFFFFFFFF, timer_irq=0, err_unmapped=0, FIFO empty (tx_valid=0, count=0), overflow=0; tx_data value is don't-care.
REQ-031 SHALL discard all FIFO contents and any bus access presented in a reset cycle, including reset asserted mid-stream.

Verification
REQ-032 Write 0xDEADBEEF to 0x0010, then read 0x0010 -> rdata=0xDEADBEEF one cycle after the read; read of 0x0014 with no prior write -> X-free value only after the word has been written.
REQ-033 Write TIME=0xFFFFFFFE, CMP=0x00000001 -> TIME reads 0, 1 on the wrap; timer_irq rises the cycle after TIME==1; write STAT=1 -> timer_irq=0.
REQ-034 With tx_ready=0, push bytes 0x41..0x49 (9 pushes) -> count=8, overflow=1, bytes 0x41..0x48 retained; raise tx_ready -> 0x41..0x48 emitted in order, then tx_valid=0.
REQ-035 FIFO full, tx_ready=1, push 0x5A in the same cycle -> count stays 8, overflow stays 0, and 0x5A is emitted last.
REQ-036 Read 0x00003000 -> rdata=0, err_unmapped=1; assert reset for 1 cycle -> err_unmapped=0, tx_valid=0, TIME restarts from 0.
REQ-037 Read and write 0x0020 in the same cycle (old 0x11, new 0x22) -> rdata=0x11; next read of 0x0020 -> 0x22.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM, free-running timer with compare IRQ, and a
// console TX byte FIFO, all behind a 1-cycle registered read port.
module dmem_mmio_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq,
    output logic        err_unmapped
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   time_q, time_d;
    logic [31:0]   cmp_q, cmp_d;
    logic          irq_q, irq_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [19:0]    page;
    logic [9:0]     off;
    logic           sel_ram, sel_tmr, sel_con, unmapped;
    logic [RAW-1:0] ram_idx;
    logic           ram_we, fifo_we;
    logic           push, pop, full, empty, push_ok;
    logic [3:0]     cnt4;
    logic [31:0]    rd_mux;

    always_comb begin
        page     = addr[31:12];
        off      = addr[11:2];
        sel_ram  = (page == 20'h00000);
        sel_tmr  = (page == 20'h00001);
        sel_con  = (page == 20'h00002);
        unmapped = !(sel_ram || sel_tmr || sel_con);
        ram_idx  = addr[RAW+1:2];

        full     = (count_q == CW'(FIFO_DEPTH));
        empty    = (count_q == '0);
        cnt4     = 4'(count_q);
        pop      = !empty && tx_ready;
        push     = write && sel_con && (off == 10'd0);
        // A full FIFO still takes the push when the head leaves in the same cycle.
        push_ok  = push && (!full || pop);

        ram_we   = write && sel_ram && !reset;
        fifo_we  = push_ok && !reset;

        rd_mux = '0;
        if (sel_ram) begin
            rd_mux = ram_q[ram_idx];
        end else if (sel_tmr) begin
            case (off)
                10'd0:   rd_mux = time_q;
                10'd1:   rd_mux = cmp_q;
                10'd2:   rd_mux = {31'b0, irq_q};
                default: rd_mux = '0;
            endcase
        end else if (sel_con && off == 10'd1) begin
            rd_mux = {24'b0, cnt4, 1'b0, ovf_q, empty, full};
        end

        rdata_d = read ? rd_mux : rdata_q;

        time_d = time_q + 32'd1;
        if (write && sel_tmr && off == 10'd0) time_d = wdata;

        cmp_d = cmp_q;
        if (write && sel_tmr && off == 10'd1) cmp_d = wdata;

        // Compare match wins over a software clear in the same cycle.
        irq_d = irq_q;
        if (write && sel_tmr && off == 10'd2 && wdata[0]) irq_d = 1'b0;
        if (time_q == cmp_q) irq_d = 1'b1;

        err_d = err_q || ((read || write) && unmapped);

        ovf_d = ovf_q;
        if (write && sel_con && off == 10'd1 && wdata[2]) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;

        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) count_d = count_q + CW'(1);
        if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            time_q   <= '0;
            cmp_q    <= '1;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rdata_q  <= rdata_d;
            time_q   <= time_d;
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= wdata;
        if (fifo_we) fifo_q[wr_ptr_q] <= wdata[7:0];
    end

    assign rdata        = rdata_q;
    assign tx_data      = fifo_q[rd_ptr_q];
    assign tx_valid     = !empty;
    assign timer_irq    = irq_q;
    assign err_unmapped = err_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder: RAM, timer, console FIFO,
// unmapped access and reset behaviour.
module tb_dmem_mmio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;
    logic        err_unmapped;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_mmio_responder #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .write(write), .read(read), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .timer_irq(timer_irq), .err_unmapped(err_unmapped)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        write = 1'b1; read = 1'b0; addr = a; wdata = d;
        cyc();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        read = 1'b1; write = 1'b0; addr = a;
        cyc();
        read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_tests++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        n_tests++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_unmapped); end
        reset = 1'b0;
        do_read(32'h0000_1004);
        n_tests++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp got=%h exp=ffffffff", rdata); end
        do_read(32'h0000_2004);
        n_tests++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_txstat got=%h exp=00000002", rdata); end
    endtask

    task automatic test_ram();
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        do_read(32'h0000_0010);
        n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_read got=%h exp=deadbeef", rdata); end
        cyc();
        n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_hold got=%h exp=deadbeef", rdata); end
        do_write(32'h0000_0014, 32'h1234_5678);
        do_read(32'h0000_0014);
        n_tests++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_read14 got=%h exp=12345678", rdata); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_write(32'h40 + 32'(i * 4), 32'hA000_0000 + 32'(i));
        read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h40 + 32'(i * 4);
            cyc();
            n_tests++;
            if (rdata !== 32'hA000_0000 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_read%0d got=%h exp=%h", i, rdata, 32'hA000_0000 + 32'(i));
            end
        end
        read = 1'b0;
    endtask

    task automatic test_rw_same();
        do_write(32'h0000_0020, 32'h11);
        read = 1'b1; write = 1'b1; addr = 32'h0000_0020; wdata = 32'h22;
        cyc();
        read = 1'b0; write = 1'b0;
        n_tests++; if (rdata !== 32'h11) begin n_fail++; $display("FAIL rw_same_old got=%h exp=11", rdata); end
        do_read(32'h0000_0020);
        n_tests++; if (rdata !== 32'h22) begin n_fail++; $display("FAIL rw_same_new got=%h exp=22", rdata); end
    endtask

    task automatic test_timer();
        logic [31:0] exp_t [4];
        exp_t[0] = 32'hFFFF_FFFE; exp_t[1] = 32'hFFFF_FFFF; exp_t[2] = 32'h0; exp_t[3] = 32'h1;
        do_write(32'h0000_1004, 32'h1);
        do_write(32'h0000_1000, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            do_read(32'h0000_1000);
            n_tests++; if (rdata !== exp_t[i]) begin n_fail++; $display("FAIL time_wrap%0d got=%h exp=%h", i, rdata, exp_t[i]); end
            if (i == 2) begin
                n_tests++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b exp=0", timer_irq); end
            end
        end
        n_tests++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1", timer_irq); end
        do_read(32'h0000_1008);
        n_tests++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL stat_read got=%h exp=1", rdata); end
        do_write(32'h0000_1008, 32'h1);
        n_tests++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
        // Clear issued in the very cycle TIME matches CMP: the match must win.
        do_write(32'h0000_1004, 32'h100);
        do_write(32'h0000_1000, 32'h100);
        do_write(32'h0000_1008, 32'h1);
        n_tests++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_prio got=%b exp=1", timer_irq); end
        do_write(32'h0000_1008, 32'h1);
        n_tests++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear2 got=%b exp=0", timer_irq); end
        do_read(32'h0000_100C);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL tmr_undef got=%h exp=0", rdata); end
        n_tests++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL tmr_undef_err got=%b exp=0", err_unmapped); end
    endtask

    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_write(32'h0000_2000, 32'h41 + 32'(i));
        do_read(32'h0000_2004);
        n_tests++; if (rdata !== 32'h85) begin n_fail++; $display("FAIL ovf_txstat got=%h exp=85", rdata); end
        do_read(32'h0000_2000);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL txdata_read got=%h exp=0", rdata); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                n_fail++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            cyc();
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got=%b exp=0", tx_valid); end
        do_write(32'h0000_2004, 32'h4);
        do_read(32'h0000_2004);
        n_tests++; if (rdata !== 32'h02) begin n_fail++; $display("FAIL ovf_clear got=%h exp=02", rdata); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b [8];
        for (int i = 0; i < 7; i++) exp_b[i] = 8'(8'h51 + i);
        exp_b[7] = 8'h5A;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(32'h0000_2000, 32'h50 + 32'(i));
        tx_ready = 1'b1;
        do_write(32'h0000_2000, 32'h5A);
        tx_ready = 1'b0;
        do_read(32'h0000_2004);
        n_tests++; if (rdata !== 32'h81) begin n_fail++; $display("FAIL fpp_txstat got=%h exp=81", rdata); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                n_fail++; $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b[i]);
            end
            cyc();
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_unmapped_reset();
        do_read(32'h0000_3000);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rdata got=%h exp=0", rdata); end
        n_tests++; if (err_unmapped !== 1'b1) begin n_fail++; $display("FAIL unmapped_err got=%b exp=1", err_unmapped); end
        tx_ready = 1'b0;
        do_write(32'h0000_2000, 32'h33);
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got=%b exp=1", tx_valid); end
        reset = 1'b1; write = 1'b1; addr = 32'h0000_0010; wdata = 32'h0000_0BAD;
        cyc();
        reset = 1'b0; write = 1'b0;
        n_tests++; if (err_unmapped !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_unmapped); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        do_read(32'h0000_1000);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_time0 got=%h exp=0", rdata); end
        do_read(32'h0000_1000);
        n_tests++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL rst_time1 got=%h exp=1", rdata); end
        do_read(32'h0000_0010);
        n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_write_dropped got=%h exp=deadbeef", rdata); end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
        cyc();
        test_reset();
        test_ram();
        test_back_to_back();
        test_rw_same();
        test_timer();
        test_fifo_overflow();
        test_full_push_pop();
        test_unmapped_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
